// File: rtl/clock_div_pkg.sv
// Shared constants for the clock divider bank: the reset divisor and the
// width helper used to size the channel-select port.
package clock_div_pkg;

    // Reset divisor; gives a half-period of 6 system clocks.
    localparam int CLK_DEFAULT_DIV = 5;

    // Width of a channel index, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clock_div_channel.sv
// One programmable divider channel: counts to div, then toggles clk_out and
// pulses tick. Priority is reset > sync > ld > count.
module clock_div_channel
    import clock_div_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = CLK_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sync,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_div,
    output logic             clk_out,
    output logic             tick
);

    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] cnt;

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (reset) begin
            div     <= WIDTH'(DEFAULT_DIV);
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (sync) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (ld) begin
            // A load on the terminal-count cycle suppresses that toggle.
            div  <= ld_div;
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            if (cnt == div) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
                tick    <= 1'b1;
            end else begin
                cnt  <= cnt + WIDTH'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of CHANNELS independent divider channels sharing one system clock,
// with a common phase-align strobe and an addressed divisor write port.
module clock_divider_bank
    import clock_div_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = CLK_DEFAULT_DIV
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            enable,
    input  logic                           sync,
    input  logic                           load,
    input  logic [idx_width(CHANNELS)-1:0] load_ch,
    input  logic [WIDTH-1:0]               load_div,
    output logic [CHANNELS-1:0]            clk_out,
    output logic [CHANNELS-1:0]            tick
);

    localparam int IW = idx_width(CHANNELS);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic ld;

        // An index beyond the last channel matches no decoder, so it is dropped.
        assign ld = load && (load_ch == IW'(i));

        clock_div_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_channel (
            .clk     (clk),
            .reset   (reset),
            .sync    (sync),
            .en      (enable[i]),
            .ld      (ld),
            .ld_div  (load_div),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench for clock_divider_bank: directed latency/priority steps
// followed by randomized traffic, all against a countdown reference model.
module tb_clock_divider_bank;

    localparam int CH = 5;   // five channels so indices 5..7 are out of range
    localparam int W  = 8;

    logic          clk = 1'b0;
    logic          reset, sync, load;
    logic [CH-1:0] enable;
    logic [2:0]    load_ch;
    logic [W-1:0]  load_div;
    logic [CH-1:0] clk_out, tick;

    int checks   = 0;
    int failures = 0;

    // Reference: edges remaining until the next toggle, per channel.
    int            m_div  [CH];
    int            m_left [CH];
    logic [CH-1:0] m_clk, m_tick;

    clock_divider_bank #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .sync     (sync),
        .load     (load),
        .load_ch  (load_ch),
        .load_div (load_div),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < CH; i++) begin
            if (reset) begin
                m_div[i] = 5; m_left[i] = 6; m_clk[i] = 1'b0; m_tick[i] = 1'b0;
            end else if (sync) begin
                m_left[i] = m_div[i] + 1; m_clk[i] = 1'b0; m_tick[i] = 1'b0;
            end else if (load && int'(load_ch) == i) begin
                m_div[i] = int'(load_div); m_left[i] = m_div[i] + 1; m_tick[i] = 1'b0;
            end else if (enable[i]) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    m_clk[i]  = ~m_clk[i];
                    m_tick[i] = 1'b1;
                    m_left[i] = m_div[i] + 1;
                end else begin
                    m_tick[i] = 1'b0;
                end
            end else begin
                m_tick[i] = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("model_clk_out", 32'(clk_out), 32'(m_clk));
        check("model_tick", 32'(tick), 32'(m_tick));
    endtask

    initial begin
        reset = 1'b1; sync = 1'b0; load = 1'b0;
        load_ch = '0; load_div = '0; enable = '1;
        m_clk = '0; m_tick = '0;
        for (int i = 0; i < CH; i++) begin m_div[i] = 5; m_left[i] = 6; end

        // Reset state and default latency: rise at edge 6, fall at edge 12.
        cycle(); cycle();
        check("reset_clk_out", 32'(clk_out), 0);
        check("reset_tick", 32'(tick), 0);
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            if (k == 5)  check("edge5_low", 32'(clk_out), 0);
            if (k == 6)  check("edge6_high", 32'(clk_out), 32'h1f);
            if (k == 6)  check("edge6_tick", 32'(tick), 32'h1f);
            if (k == 7)  check("edge7_notick", 32'(tick), 0);
            if (k == 11) check("edge11_high", 32'(clk_out), 32'h1f);
            if (k == 12) check("edge12_low", 32'(clk_out), 0);
            if (k == 12) check("edge12_tick", 32'(tick), 32'h1f);
        end

        // ch1 -> div 0 (clk/2), ch2 -> div 2 (period 6).
        load = 1'b1; load_ch = 3'd1; load_div = 8'd0;
        cycle();
        load_ch = 3'd2; load_div = 8'd2;
        cycle();
        load = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            check("ch1_div0_tick", 32'(tick[1]), 1);
        end

        // Freeze ch0 at cnt=3 for 4 cycles, then 3 enabled edges to toggle.
        sync = 1'b1; cycle();
        check("sync_all_low", 32'(clk_out), 0);
        sync = 1'b0;
        cycle(); cycle(); cycle();
        enable = 5'b11110;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("freeze_ch0_clk", 32'(clk_out[0]), 0);
            check("freeze_ch0_tick", 32'(tick[0]), 0);
        end
        enable = '1;
        cycle(); cycle();
        check("resume_ch0_wait", 32'(clk_out[0]), 0);
        cycle();
        check("resume_ch0_toggle", 32'(clk_out[0]), 1);
        check("resume_ch0_tick", 32'(tick[0]), 1);

        // Load div 9 on ch0's terminal-count cycle: load wins.
        sync = 1'b1; cycle(); sync = 1'b0;
        for (int k = 0; k < 5; k++) cycle();
        load = 1'b1; load_ch = 3'd0; load_div = 8'd9;
        cycle();
        check("tc_load_no_toggle", 32'(clk_out[0]), 0);
        check("tc_load_no_tick", 32'(tick[0]), 0);
        load = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (k < 10)  check("tc_load_wait", 32'(clk_out[0]), 0);
            if (k == 10) check("tc_load_toggle", 32'(clk_out[0]), 1);
        end

        // Free-running divs 3,5,7,5 then sync: ch1 and ch3 run in phase.
        load = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load_ch = 3'(i); load_div = 8'(3 + 2 * (i % 2 == 0 ? i : 1));
            if (i == 3) load_div = 8'd5;
            cycle();
        end
        load = 1'b0;
        for (int k = 0; k < int'($urandom_range(3, 20)); k++) cycle();
        sync = 1'b1; cycle();
        check("sync2_all_low", 32'(clk_out), 0);
        sync = 1'b0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            check("ch3_phase_ch1", 32'(clk_out[3]), 32'(m_clk[1]));
        end

        // Out-of-range channel writes are dropped.
        load = 1'b1; load_div = 8'd1;
        for (int c = 5; c < 8; c++) begin load_ch = 3'(c); cycle(); end
        load = 1'b0;
        for (int k = 0; k < 10; k++) cycle();

        // Reset mid-half-period restores defaults with no partial pulse.
        cycle(); cycle(); cycle();
        reset = 1'b1; cycle();
        check("midreset_clk_out", 32'(clk_out), 0);
        check("midreset_tick", 32'(tick), 0);
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            if (k == 6) check("midreset_default_div", 32'(clk_out), 32'h1f);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            reset    = ($urandom_range(0, 63) == 0);
            sync     = ($urandom_range(0, 31) == 0);
            load     = ($urandom_range(0, 3) == 0);
            load_ch  = 3'($urandom_range(0, 7));
            load_div = 8'($urandom_range(0, 15));
            for (int i = 0; i < CH; i++) enable[i] = ($urandom_range(0, 4) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
